// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline sequencing controller and the datapath:
// hazard/branch/memory/halt status in, register enables, flushes and status out.
interface pipeline_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             id_halt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_reg_wren;
    logic             ex_mem_to_reg;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_wren;
    logic             if_id_wren;
    logic             id_ex_wren;
    logic             ex_mem_wren;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    // The datapath side drives status and consumes the enables.
    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_halt,
               ex_rd, ex_reg_wren, ex_mem_to_reg, ex_branch_taken,
               mem_req, mem_ready,
        input  pc_wren, if_id_wren, id_ex_wren, ex_mem_wren,
               if_id_flush, id_ex_flush, mem_wb_bubble, halted, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_halt,
               ex_rd, ex_reg_wren, ex_mem_to_reg, ex_branch_taken,
               mem_req, mem_ready,
        output pc_wren, if_id_wren, id_ex_wren, ex_mem_wren,
               if_id_flush, id_ex_flush, mem_wb_bubble, halted, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: decides advance/hold/bubble for every pipeline
// register from load-use, taken-branch, data-memory wait and halt, and counts stalls.
module pipeline_ctrl #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    pipeline_ctrl_if.slave   ctrl
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             memWait_q, memWait_d;
    logic [1:0]       drainCnt_q, drainCnt_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic freeze;
    logic loadUse;
    logic stallCycle;

    // The first cycle of every access is frozen; the mem_ready cycle is not.
    assign freeze = (!memWait_q && ctrl.mem_req) || (memWait_q && !ctrl.mem_ready);

    assign loadUse = ctrl.ex_reg_wren && ctrl.ex_mem_to_reg &&
                     (ctrl.ex_rd != REG_W'(0)) &&
                     ((ctrl.id_rs_used && (ctrl.id_rs == ctrl.ex_rd)) ||
                      (ctrl.id_rt_used && (ctrl.id_rt == ctrl.ex_rd)));

    assign stallCycle = (state_q != HALTED) &&
                        (freeze || (state_q == RUN && loadUse && !ctrl.ex_branch_taken));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            memWait_q  <= 1'b0;
            drainCnt_q <= 2'd0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            memWait_q  <= memWait_d;
            drainCnt_q <= drainCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        memWait_d  = memWait_q;
        drainCnt_d = drainCnt_q;
        stallCnt_d = stallCnt_q;

        ctrl.pc_wren       = 1'b1;
        ctrl.if_id_wren    = 1'b1;
        ctrl.id_ex_wren    = 1'b1;
        ctrl.ex_mem_wren   = 1'b1;
        ctrl.if_id_flush   = 1'b0;
        ctrl.id_ex_flush   = 1'b0;
        ctrl.mem_wb_bubble = 1'b0;
        ctrl.halted        = (state_q == HALTED);
        ctrl.stall_cnt     = stallCnt_q;

        if (!memWait_q && ctrl.mem_req) begin
            memWait_d = 1'b1;
        end else if (memWait_q && ctrl.mem_ready) begin
            memWait_d = 1'b0;
        end

        if (stallCycle && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end

        if (rst) begin
            ctrl.pc_wren       = 1'b0;
            ctrl.if_id_wren    = 1'b0;
            ctrl.id_ex_wren    = 1'b0;
            ctrl.ex_mem_wren   = 1'b0;
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_ex_flush   = 1'b1;
            ctrl.mem_wb_bubble = 1'b1;
            ctrl.halted        = 1'b0;
        end else if (freeze) begin
            // Everything holds; only WB is bubbled so it does not commit twice.
            ctrl.pc_wren       = 1'b0;
            ctrl.if_id_wren    = 1'b0;
            ctrl.id_ex_wren    = 1'b0;
            ctrl.ex_mem_wren   = 1'b0;
            ctrl.mem_wb_bubble = 1'b1;
        end else begin
            case (state_q)
                HALTED: begin
                    ctrl.pc_wren       = 1'b0;
                    ctrl.if_id_wren    = 1'b0;
                    ctrl.id_ex_wren    = 1'b0;
                    ctrl.ex_mem_wren   = 1'b0;
                    ctrl.mem_wb_bubble = 1'b1;
                end
                DRAIN: begin
                    ctrl.pc_wren     = 1'b0;
                    ctrl.if_id_wren  = 1'b0;
                    ctrl.id_ex_flush = 1'b1;
                    drainCnt_d       = drainCnt_q - 2'd1;
                    if (drainCnt_d == 2'd0) begin
                        state_d = HALTED;
                    end
                end
                RUN: begin
                    if (ctrl.ex_branch_taken) begin
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (loadUse) begin
                        ctrl.pc_wren     = 1'b0;
                        ctrl.if_id_wren  = 1'b0;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (ctrl.id_halt) begin
                        // HLT moves on to EX and the two older instructions drain out.
                        ctrl.pc_wren    = 1'b0;
                        ctrl.if_id_wren = 1'b0;
                        state_d         = DRAIN;
                        drainCnt_d      = 2'd2;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a vector table plus hand-written
// multi-cycle sequences feed a scoreboard of expected per-cycle outputs.
module tb_pipeline_ctrl;

    typedef logic [23:0] exp_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       rsU;
        logic       rtU;
        logic       halt;
        logic [3:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct {
        string name;
        in_t   in;
        exp_t  exp;
    } vec_t;

    typedef struct {
        string name;
        exp_t  exp;
    } sb_t;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    vec_t vecs[$];
    sb_t  scoreboard[$];

    pipeline_ctrl_if #(.REG_W(4), .CNT_W(16)) bus ();
    pipeline_ctrl_if #(.REG_W(4), .CNT_W(2))  satBus ();

    pipeline_ctrl #(.REG_W(4), .CNT_W(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    pipeline_ctrl #(.REG_W(4), .CNT_W(2)) dutSat (
        .clk  (clk),
        .rst  (rst),
        .ctrl (satBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output patterns: {pc,if_id,id_ex,ex_mem wren}, {if_id,id_ex flush, wb bubble}, halted, stall_cnt
    function automatic exp_t expRun(input logic [15:0] c);   return {4'b1111, 3'b000, 1'b0, c}; endfunction
    function automatic exp_t expLu(input logic [15:0] c);    return {4'b0011, 3'b010, 1'b0, c}; endfunction
    function automatic exp_t expBr(input logic [15:0] c);    return {4'b1111, 3'b110, 1'b0, c}; endfunction
    function automatic exp_t expHltId(input logic [15:0] c); return {4'b0011, 3'b000, 1'b0, c}; endfunction
    function automatic exp_t expDrain(input logic [15:0] c); return {4'b0011, 3'b010, 1'b0, c}; endfunction
    function automatic exp_t expFrz(input logic [15:0] c);   return {4'b0000, 3'b001, 1'b0, c}; endfunction
    function automatic exp_t expHalted(input logic [15:0] c);return {4'b0000, 3'b001, 1'b1, c}; endfunction
    function automatic exp_t expRst(input logic [15:0] c);   return {4'b0000, 3'b111, 1'b0, c}; endfunction

    function automatic in_t inp(input logic r, input logic [3:0] rs, input logic [3:0] rt,
                                input logic rsU, input logic rtU, input logic halt,
                                input logic [3:0] rd, input logic wr, input logic ld,
                                input logic br, input logic req, input logic rdy);
        in_t v;
        v = '{rst: r, rs: rs, rt: rt, rsU: rsU, rtU: rtU, halt: halt,
              rd: rd, wr: wr, ld: ld, br: br, req: req, rdy: rdy};
        return v;
    endfunction

    function automatic in_t idle();
        return inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic addVec(input string name, input in_t in, input exp_t e);
        vec_t v;
        v.name = name;
        v.in   = in;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs just after the edge and records what the DUT owes us.
    task automatic applyStimulus(input string name, input in_t in, input exp_t e);
        sb_t s;
        @(posedge clk);
        #1;
        rst                 = in.rst;
        bus.id_rs           = in.rs;
        bus.id_rt           = in.rt;
        bus.id_rs_used      = in.rsU;
        bus.id_rt_used      = in.rtU;
        bus.id_halt         = in.halt;
        bus.ex_rd           = in.rd;
        bus.ex_reg_wren     = in.wr;
        bus.ex_mem_to_reg   = in.ld;
        bus.ex_branch_taken = in.br;
        bus.mem_req         = in.req;
        bus.mem_ready       = in.rdy;
        s.name = name;
        s.exp  = e;
        scoreboard.push_back(s);
    endtask

    // Samples on the falling edge, away from the state update.
    task automatic checkOutput();
        sb_t  s;
        exp_t act;
        @(negedge clk);
        if (scoreboard.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard: empty queue when output sampled");
        end else begin
            s   = scoreboard.pop_front();
            act = {bus.pc_wren, bus.if_id_wren, bus.id_ex_wren, bus.ex_mem_wren,
                   bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble, bus.halted, bus.stall_cnt};
            compare(s.name, {8'd0, act}, {8'd0, s.exp});
        end
    endtask

    task automatic step(input string name, input in_t in, input exp_t e);
        applyStimulus(name, in, e);
        checkOutput();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        rst = 1'b1;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rs_used = 0; bus.id_rt_used = 0;
        bus.id_halt = 0; bus.ex_rd = '0; bus.ex_reg_wren = 0; bus.ex_mem_to_reg = 0;
        bus.ex_branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
        satBus.id_rs = '0; satBus.id_rt = '0; satBus.id_rs_used = 0; satBus.id_rt_used = 0;
        satBus.id_halt = 0; satBus.ex_rd = '0; satBus.ex_reg_wren = 0; satBus.ex_mem_to_reg = 0;
        satBus.ex_branch_taken = 0; satBus.mem_req = 0; satBus.mem_ready = 0;
        repeat (2) @(posedge clk);

        //                 r  rs rt rsU rtU hlt rd wr ld br req rdy
        addVec("reset",         inp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), expRst(0));
        addVec("idle",          idle(),                                  expRun(0));
        addVec("loaduse rs",    inp(0, 3, 0, 1, 0, 0, 3, 1, 1, 0, 0, 0), expLu(0));
        addVec("after loaduse", idle(),                                  expRun(1));
        addVec("loaduse rd0",   inp(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0), expRun(1));
        addVec("loaduse rt",    inp(0, 5, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0), expLu(1));
        addVec("rs unused",     inp(0, 5, 6, 0, 1, 0, 5, 1, 1, 0, 0, 0), expRun(2));
        addVec("not a load",    inp(0, 5, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0), expRun(2));
        addVec("branch+lu",     inp(0, 3, 0, 1, 0, 0, 3, 1, 1, 1, 0, 0), expBr(2));
        addVec("branch+halt",   inp(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), expBr(2));
        addVec("idle2",         idle(),                                  expRun(2));
        addVec("mem frz1",      inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), expFrz(2));
        addVec("mem frz2",      inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), expFrz(3));
        addVec("mem frz3",      inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), expFrz(4));
        addVec("mem ready",     inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), expRun(5));
        addVec("idle3",         idle(),                                  expRun(5));
        addVec("stray ready",   inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), expRun(5));
        addVec("frz+lu",        inp(0, 3, 0, 1, 0, 0, 3, 1, 1, 0, 1, 0), expFrz(5));
        addVec("lu deferred",   inp(0, 3, 0, 1, 0, 0, 3, 1, 1, 0, 1, 1), expLu(6));
        addVec("idle4",         idle(),                                  expRun(7));
        addVec("frz+br",        inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), expFrz(7));
        addVec("br deferred",   inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), expBr(8));
        addVec("idle5",         idle(),                                  expRun(8));

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].in, vecs[i].exp);
        end

        // Plain halt: halted three unfrozen cycles after HLT sits in ID, then sticky.
        step("hlt in id",      inp(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), expHltId(8));
        step("drain1",         idle(),                                  expDrain(8));
        step("drain2",         idle(),                                  expDrain(8));
        step("halted",         idle(),                                  expHalted(8));
        step("halted idle",    idle(),                                  expHalted(8));
        step("halted br+hlt",  inp(0, 3, 0, 1, 0, 1, 3, 1, 1, 1, 0, 0), expHalted(8));
        step("halted memreq",  inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), expHalted(8));
        step("rst in halted",  inp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), expRst(8));
        step("run after rst",  idle(),                                  expRun(0));

        // Halt with a one-cycle memory freeze in DRAIN: halted slips by one cycle.
        step("hlt2 in id",     inp(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), expHltId(0));
        step("drain2 1",       idle(),                                  expDrain(0));
        step("drain2 frz",     inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), expFrz(0));
        step("drain2 2",       inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), expDrain(1));
        step("halted2",        idle(),                                  expHalted(1));

        // Reset mid-drain and mid-mem_wait.
        step("rst halted2",    inp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), expRst(1));
        step("run after rst2", idle(),                                  expRun(0));
        step("hlt3 in id",     inp(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), expHltId(0));
        step("drain3 1",       idle(),                                  expDrain(0));
        step("rst mid drain",  inp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), expRst(0));
        step("run after rst3", idle(),                                  expRun(0));
        step("memwait frz",    inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), expFrz(0));
        step("rst mid wait",   inp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), expRst(1));
        step("run after rst4", idle(),                                  expRun(0));

        // Saturation on the 2-bit counter instance: five frozen cycles stick at 3.
        for (int i = 0; i <= 5; i++) begin
            applyStimulus("sat main idle", idle(), expRun(0));
            satBus.mem_req   = 1'b1;
            satBus.mem_ready = 1'b0;
            checkOutput();
            compare($sformatf("sat cnt %0d", i), {30'd0, satBus.stall_cnt},
                    (i > 3) ? 32'd3 : 32'(i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
